ddr3_sram_responder: RTL and testbench

//  - Memory-controller-side responder for the mem_* request/data interface driven by the AXI-to-memory command converter.
//  - Accepts WRITE and READ burst requests, then stores or fetches fixed-length bursts to or from an internal single-port SRAM.
//  - Acts as a synthesisable stand-in for the DDR3 controller + DFI datapath.
//  - Used for AXI-front-end bring-up, system simulation and FPGA builds without external DRAM.

---
 rtl/ddr3_sram_responder.sv | 255 +++++++++++++++++++++++++
 tb/tb_ddr3_sram_responder.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_sram_responder.sv
// ddr3_sram_responder
//   Stand-in for a DDR3 controller plus DFI datapath. It accepts burst requests
//   from the AXI-to-memory command converter on the mem_* interface and services
//   fixed-length bursts to or from an internal single-port SRAM.
//
// Ports
//   clock, reset               system clock; synchronous active-high reset
//   mem_wrreq_i / mem_wrack_o  write request (held) / 1-cycle accept pulse
//   mem_wrerr_o                write error, coincident with mem_wrack_o
//   mem_wrlst_i, mem_wrtid_i   sampled but unused
//   mem_wradr_i                write byte address
//   mem_valid_i / mem_ready_o  write-data beat handshake
//   mem_wlast_i                early end of the write burst
//   mem_wmask_i, mem_wdata_i   byte enables (1 = write lane) and write data
//   mem_rdreq_i / mem_rdack_o  read request (held) / 1-cycle accept pulse
//   mem_rderr_o                read error, coincident with mem_rdack_o
//   mem_rdtid_i                sampled but unused
//   mem_rdadr_i                read byte address
//   mem_valid_o / mem_ready_i  read-data beat handshake
//   mem_rlast_o, mem_rdata_o   final-beat flag and read data
//
// Configuration
//   DDR3_SRAM_RESPONDER_ADDR_CHECK_EN: requests at or beyond the SRAM size are
//   acked with err = 1; their write beats are discarded and their read beats
//   return zero. When undefined, addresses wrap modulo the SRAM size and the
//   error outputs stay 0.

module ddr3_sram_responder #(
   parameter int unsigned ADDRS         = 32,
   parameter int unsigned WIDTH         = 32,
   parameter int unsigned MASKS         = WIDTH / 8,
   parameter int unsigned MEM_ID_WIDTH  = 4,
   parameter int unsigned MEM_BURST_LEN = 4,
   parameter int unsigned SRAM_WORDS    = 1024
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    mem_wrreq_i,
   output logic                    mem_wrack_o,
   output logic                    mem_wrerr_o,
   input  logic                    mem_wrlst_i,
   input  logic [MEM_ID_WIDTH-1:0] mem_wrtid_i,
   input  logic [ADDRS-1:0]        mem_wradr_i,
   input  logic                    mem_valid_i,
   output logic                    mem_ready_o,
   input  logic                    mem_wlast_i,
   input  logic [MASKS-1:0]        mem_wmask_i,
   input  logic [WIDTH-1:0]        mem_wdata_i,
   input  logic                    mem_rdreq_i,
   output logic                    mem_rdack_o,
   output logic                    mem_rderr_o,
   input  logic [MEM_ID_WIDTH-1:0] mem_rdtid_i,
   input  logic [ADDRS-1:0]        mem_rdadr_i,
   output logic                    mem_valid_o,
   input  logic                    mem_ready_i,
   output logic                    mem_rlast_o,
   output logic [WIDTH-1:0]        mem_rdata_o
);

   localparam int unsigned LaneBits = $clog2(MASKS);
   localparam int unsigned IdxBits  = $clog2(SRAM_WORDS);
   localparam int unsigned BeatBits = $clog2(MEM_BURST_LEN);
   localparam int unsigned CntBits  = BeatBits + 1;
   localparam logic [CntBits-1:0] LastBeat = CntBits'(MEM_BURST_LEN - 1);
   localparam logic [CntBits-1:0] NumBeats = CntBits'(MEM_BURST_LEN);

   typedef logic [IdxBits-1:0] idx_t;
   typedef enum logic [2:0] {StIdle, StAckWr, StWrite, StAckRd, StRead} state_e;

   state_e               state_q, state_d;
   logic                 prefer_rd_q, prefer_rd_d;
   idx_t                 base_q, base_d;
   logic                 err_q, err_d;
   logic [CntBits-1:0]   beat_q, beat_d;   // write beats taken / read words issued
   logic [CntBits-1:0]   out_q, out_d;     // read beats handed out
   logic                 rd_vld_q;
   logic [WIDTH-1:0]     rd_data_q;
   logic [WIDTH-1:0]     buf_q [2];
   logic                 wr_ptr_q, rd_ptr_q;
   logic [1:0]           cnt_q, cnt_d;
   logic [WIDTH-1:0]     sram_q [SRAM_WORDS];

   logic                 grant_wr, grant_rd;
   logic [ADDRS-1:0]     req_adr;
   logic [IdxBits-BeatBits-1:0] req_blk;
   logic                 req_err;
   idx_t                 sram_addr;
   logic                 wr_beat, wr_end, sram_we;
   logic                 rd_issue, credit, pop, rd_end, buf_valid;
   logic [1:0]           occ;
   logic                 unused_inputs;

   assign unused_inputs = ^{mem_wrlst_i, mem_wrtid_i, mem_rdtid_i, mem_wradr_i, mem_rdadr_i};

   // Round-robin arbitration: on a tie the side not served last wins.
   always_comb begin
      grant_wr = 1'b0;
      grant_rd = 1'b0;
      if (state_q == StIdle) begin
         if (mem_wrreq_i && mem_rdreq_i) begin
            grant_rd = prefer_rd_q;
            grant_wr = !prefer_rd_q;
         end else begin
            grant_wr = mem_wrreq_i;
            grant_rd = mem_rdreq_i;
         end
      end
   end

   assign req_adr = grant_wr ? mem_wradr_i : mem_rdadr_i;
   // Burst-aligned word index: low beat bits of the word address are dropped.
   assign req_blk = req_adr[LaneBits+BeatBits +: IdxBits-BeatBits];

`ifdef DDR3_SRAM_RESPONDER_ADDR_CHECK_EN
   assign req_err = |req_adr[ADDRS-1:LaneBits+IdxBits];
`else
   assign req_err = 1'b0;
`endif

   always_comb begin
      prefer_rd_d = prefer_rd_q;
      base_d      = base_q;
      err_d       = err_q;
      if (grant_wr || grant_rd) begin
         prefer_rd_d = grant_wr;
         base_d      = {req_blk, {BeatBits{1'b0}}};
         err_d       = req_err;
      end
   end

   assign sram_addr = base_q | idx_t'(beat_q[BeatBits-1:0]);
   assign wr_beat   = (state_q == StWrite) && mem_valid_i;
   assign wr_end    = wr_beat && (mem_wlast_i || (beat_q == LastBeat));
   assign sram_we   = wr_beat && !err_q && !reset;

   // Read issue is credited against the 2-entry buffer: words already buffered
   // plus the one in the SRAM pipe, less the beat leaving this cycle.
   assign buf_valid = (cnt_q != 2'd0);
   assign pop       = buf_valid && mem_ready_i;
   assign occ       = cnt_q + {1'b0, rd_vld_q};
   assign credit    = (occ < 2'd2) || pop;
   assign rd_issue  = ((state_q == StAckRd) || (state_q == StRead)) &&
                      (beat_q < NumBeats) && credit;
   assign rd_end    = pop && (out_q == LastBeat);

   always_comb begin
      beat_d = beat_q;
      if (state_q == StIdle) begin
         beat_d = '0;
      end else if (wr_beat || rd_issue) begin
         beat_d = beat_q + CntBits'(1);
      end
   end

   always_comb begin
      out_d = out_q;
      if (state_q == StIdle) begin
         out_d = '0;
      end else if (pop) begin
         out_d = out_q + CntBits'(1);
      end
   end

   assign cnt_d = cnt_q + {1'b0, rd_vld_q} - {1'b0, pop};

   // State register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (grant_wr) begin
               state_d = StAckWr;
            end else if (grant_rd) begin
               state_d = StAckRd;
            end
         end
         StAckWr: state_d = StWrite;
         StWrite: if (wr_end) state_d = StIdle;
         StAckRd: state_d = StRead;
         StRead:  if (rd_end) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Outputs.
   always_comb begin
      mem_wrack_o = (state_q == StAckWr);
      mem_wrerr_o = (state_q == StAckWr) && err_q;
      mem_rdack_o = (state_q == StAckRd);
      mem_rderr_o = (state_q == StAckRd) && err_q;
      mem_ready_o = (state_q == StWrite);
      mem_valid_o = buf_valid;
      mem_rlast_o = buf_valid && (out_q == LastBeat);
      mem_rdata_o = buf_valid ? buf_q[rd_ptr_q] : '0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         prefer_rd_q <= 1'b0;
         base_q      <= '0;
         err_q       <= 1'b0;
         beat_q      <= '0;
         out_q       <= '0;
         rd_vld_q    <= 1'b0;
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         cnt_q       <= '0;
      end else begin
         prefer_rd_q <= prefer_rd_d;
         base_q      <= base_d;
         err_q       <= err_d;
         beat_q      <= beat_d;
         out_q       <= out_d;
         rd_vld_q    <= rd_issue;
         cnt_q       <= cnt_d;
         if (rd_vld_q) begin
            wr_ptr_q <= !wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= !rd_ptr_q;
         end
      end
   end

   // Single-port SRAM: writes only in StWrite, reads only in StAckRd/StRead.
   // Contents have no reset and survive a reset. Error bursts read as zero.
   always_ff @(posedge clock) begin
      if (sram_we) begin
         for (int unsigned i = 0; i < MASKS; i++) begin
            if (mem_wmask_i[i]) begin
               sram_q[sram_addr][i*8 +: 8] <= mem_wdata_i[i*8 +: 8];
            end
         end
      end
      if (rd_issue) begin
         rd_data_q <= err_q ? '0 : sram_q[sram_addr];
      end
   end

   always_ff @(posedge clock) begin
      if (rd_vld_q) begin
         buf_q[wr_ptr_q] <= rd_data_q;
      end
   end

endmodule

// File: tb/tb_ddr3_sram_responder.sv
module tb_ddr3_sram_responder;

   localparam int unsigned BL = 4;
   typedef logic [BL-1:0][31:0] burst_t;
   typedef logic [BL-1:0][3:0]  masks_t;

   logic        clock;
   logic        reset;
   logic        mem_wrreq_i, mem_wrack_o, mem_wrerr_o, mem_wrlst_i;
   logic [3:0]  mem_wrtid_i;
   logic [31:0] mem_wradr_i;
   logic        mem_valid_i, mem_ready_o, mem_wlast_i;
   logic [3:0]  mem_wmask_i;
   logic [31:0] mem_wdata_i;
   logic        mem_rdreq_i, mem_rdack_o, mem_rderr_o;
   logic [3:0]  mem_rdtid_i;
   logic [31:0] mem_rdadr_i;
   logic        mem_valid_o, mem_ready_i, mem_rlast_o;
   logic [31:0] mem_rdata_o;

   int checks = 0;
   int fails  = 0;
   logic [31:0] model [1024];

   ddr3_sram_responder dut (
      .clock       (clock),
      .reset       (reset),
      .mem_wrreq_i (mem_wrreq_i),
      .mem_wrack_o (mem_wrack_o),
      .mem_wrerr_o (mem_wrerr_o),
      .mem_wrlst_i (mem_wrlst_i),
      .mem_wrtid_i (mem_wrtid_i),
      .mem_wradr_i (mem_wradr_i),
      .mem_valid_i (mem_valid_i),
      .mem_ready_o (mem_ready_o),
      .mem_wlast_i (mem_wlast_i),
      .mem_wmask_i (mem_wmask_i),
      .mem_wdata_i (mem_wdata_i),
      .mem_rdreq_i (mem_rdreq_i),
      .mem_rdack_o (mem_rdack_o),
      .mem_rderr_o (mem_rderr_o),
      .mem_rdtid_i (mem_rdtid_i),
      .mem_rdadr_i (mem_rdadr_i),
      .mem_valid_o (mem_valid_o),
      .mem_ready_i (mem_ready_i),
      .mem_rlast_o (mem_rlast_o),
      .mem_rdata_o (mem_rdata_o)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Reference model: a plain word array addressed by burst-aligned word index.
   function automatic int unsigned word_base(input logic [31:0] addr);
      return (((addr >> 2) % 1024) / BL) * BL;
   endfunction

   function automatic bit addr_err(input logic [31:0] addr);
`ifdef DDR3_SRAM_RESPONDER_ADDR_CHECK_EN
      return addr >= 32'd4096;
`else
      return (addr != addr);
`endif
   endfunction

   function automatic burst_t model_burst(input logic [31:0] addr);
      burst_t b;
      for (int i = 0; i < BL; i++) begin
         b[i] = addr_err(addr) ? 32'h0 : model[word_base(addr) + i];
      end
      return b;
   endfunction

   function automatic void model_write(input logic [31:0] addr, input burst_t data,
                                       input masks_t masks, input int nbeats);
      if (!addr_err(addr)) begin
         for (int i = 0; i < nbeats; i++) begin
            for (int l = 0; l < 4; l++) begin
               if (masks[i][l]) model[word_base(addr) + i][l*8 +: 8] = data[i][l*8 +: 8];
            end
         end
      end
   endfunction

   task automatic wait_any_ack(input string tag, output bit got_wr);
      int n = 0;
      do begin
         tick();
         n++;
      end while (!mem_wrack_o && !mem_rdack_o && n < 32);
      check({tag, "_ack_seen"}, 64'(mem_wrack_o | mem_rdack_o), 64'd1);
      check({tag, "_one_ack"}, 64'(mem_wrack_o & mem_rdack_o), 64'd0);
      got_wr = mem_wrack_o;
   endtask

   task automatic write_beats(input string tag, input burst_t data, input masks_t masks,
                              input int nbeats, input bit no_last, input bit gaps);
      tick();
      check({tag, "_ack_pulse"}, 64'(mem_wrack_o), 64'd0);
      check({tag, "_ready"}, 64'(mem_ready_o), 64'd1);
      for (int i = 0; i < nbeats; i++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               mem_valid_i = 1'b0;
               tick();
            end
         end
         mem_valid_i = 1'b1;
         mem_wdata_i = data[i];
         mem_wmask_i = masks[i];
         mem_wlast_i = (i == nbeats - 1) && !no_last;
         tick();
      end
      mem_valid_i = 1'b0;
      mem_wlast_i = 1'b0;
      check({tag, "_burst_end"}, 64'(mem_ready_o), 64'd0);
   endtask

   task automatic read_beats(input string tag, input burst_t exp, input int mode,
                             input logic [BL-1:0] skip);
      int beats = 0;
      int n = 0;
      bit held = 1'b0;
      logic [31:0] held_data = '0;
      tick();
      check({tag, "_ack_pulse"}, 64'(mem_rdack_o), 64'd0);
      check({tag, "_lat1"}, 64'(mem_valid_o), 64'd0);
      tick();
      check({tag, "_lat2"}, 64'(mem_valid_o), 64'd1);
      while (beats < BL && n < 64) begin
         case (mode)
            1:       mem_ready_i = (n % 2 == 1);
            2:       mem_ready_i = 1'($urandom_range(0, 1));
            default: mem_ready_i = 1'b1;
         endcase
         if (held) begin
            check({tag, "_hold_valid"}, 64'(mem_valid_o), 64'd1);
            check({tag, "_hold_data"}, 64'(mem_rdata_o), 64'(held_data));
         end
         held = 1'b0;
         if (mem_valid_o && mem_ready_i) begin
            if (!skip[beats]) check({tag, "_data"}, 64'(mem_rdata_o), 64'(exp[beats]));
            check({tag, "_rlast"}, 64'(mem_rlast_o), 64'(beats == BL - 1));
            beats++;
         end else if (mem_valid_o) begin
            held      = 1'b1;
            held_data = mem_rdata_o;
         end
         tick();
         n++;
      end
      mem_ready_i = 1'b0;
      check({tag, "_beats"}, 64'(beats), 64'(BL));
      check({tag, "_drained"}, 64'(mem_valid_o), 64'd0);
   endtask

   task automatic do_write(input string tag, input logic [31:0] addr, input burst_t data,
                           input masks_t masks, input int nbeats, input bit no_last,
                           input bit gaps);
      bit got_wr;
      mem_wrreq_i = 1'b1;
      mem_wradr_i = addr;
      mem_wrtid_i = 4'($urandom);
      mem_wrlst_i = 1'($urandom);
      wait_any_ack(tag, got_wr);
      check({tag, "_is_wr"}, 64'(got_wr), 64'd1);
      check({tag, "_wrerr"}, 64'(mem_wrerr_o), 64'(addr_err(addr)));
      mem_wrreq_i = 1'b0;
      write_beats(tag, data, masks, nbeats, no_last, gaps);
      model_write(addr, data, masks, nbeats);
   endtask

   task automatic do_read(input string tag, input logic [31:0] addr, input burst_t exp,
                          input int mode, input logic [BL-1:0] skip);
      bit got_wr;
      mem_rdreq_i = 1'b1;
      mem_rdadr_i = addr;
      mem_rdtid_i = 4'($urandom);
      wait_any_ack(tag, got_wr);
      check({tag, "_is_rd"}, 64'(got_wr), 64'd0);
      check({tag, "_rderr"}, 64'(mem_rderr_o), 64'(addr_err(addr)));
      mem_rdreq_i = 1'b0;
      read_beats(tag, exp, mode, skip);
   endtask

   initial begin
      burst_t      d, a, b;
      masks_t      m;
      logic [31:0] addr;
      int          nb;
      bit          got_wr;

      reset       = 1'b1;
      mem_wrreq_i = 1'b0;
      mem_wrlst_i = 1'b0;
      mem_wrtid_i = '0;
      mem_wradr_i = '0;
      mem_valid_i = 1'b0;
      mem_wlast_i = 1'b0;
      mem_wmask_i = '0;
      mem_wdata_i = '0;
      mem_rdreq_i = 1'b0;
      mem_rdtid_i = '0;
      mem_rdadr_i = '0;
      mem_ready_i = 1'b0;
      for (int i = 0; i < 1024; i++) model[i] = '0;

      repeat (3) tick();
      check("reset_outputs", 64'({mem_wrack_o, mem_wrerr_o, mem_rdack_o, mem_rderr_o,
                                  mem_ready_o, mem_valid_o, mem_rlast_o, mem_rdata_o}), 64'd0);
      reset = 1'b0;
      tick();
      check("idle_outputs", 64'({mem_wrack_o, mem_rdack_o, mem_ready_o, mem_valid_o}), 64'd0);

      // Known contents for words 0..63.
      for (int i = 0; i < 16; i++) do_write("init", 32'(i * 16), '0, '1, BL, 1'b0, 1'b0);

      // Full burst write then readback, rlast only on beat 3.
      d = {32'd4, 32'd3, 32'd2, 32'd1};
      do_write("wr_full", 32'h40, d, '1, BL, 1'b0, 1'b0);
      do_read("rd_full", 32'h40, d, 0, '0);

      // Byte-masked single-beat write terminated early by wlast.
      d = {32'h7, 32'h6, 32'h5, 32'h11223344};
      do_write("wr_base", 32'h40, d, '1, BL, 1'b0, 1'b0);
      b = '0;
      b[0] = 32'hAABBCCDD;
      m = '0;
      m[0] = 4'b0101;
      do_write("wr_mask", 32'h40, b, m, 1, 1'b0, 1'b0);
      do_read("rd_mask", 32'h40, {32'h7, 32'h6, 32'h5, 32'h11BB33DD}, 0, '0);

      // Simultaneous requests held: grants must alternate write, read, write, read.
      mem_wrreq_i = 1'b1;
      mem_rdreq_i = 1'b1;
      mem_wradr_i = 32'h80;
      mem_rdadr_i = 32'h80;
      for (int k = 0; k < 4; k++) begin
         wait_any_ack("rr", got_wr);
         check("rr_order", 64'(got_wr), 64'(k % 2 == 0));
         if (k == 3) begin
            mem_wrreq_i = 1'b0;
            mem_rdreq_i = 1'b0;
         end
         if (got_wr) begin
            for (int i = 0; i < BL; i++) d[i] = $urandom;
            write_beats("rr_w", d, '1, BL, 1'b0, 1'b0);
            model_write(32'h80, d, '1, BL);
         end else begin
            read_beats("rr_r", model_burst(32'h80), 0, '0);
         end
      end

      // Read under a 0/1 toggling ready.
      do_read("rd_toggle", 32'h40, {32'h7, 32'h6, 32'h5, 32'h11BB33DD}, 1, '0);

      // Reset in the middle of a write burst.
      a = {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0};
      do_write("rst_pre", 32'h40, a, '1, BL, 1'b0, 1'b0);
      b = {32'hB3B3B3B3, 32'hB2B2B2B2, 32'hB1B1B1B1, 32'hB0B0B0B0};
      mem_wrreq_i = 1'b1;
      mem_wradr_i = 32'h40;
      wait_any_ack("rst_wr", got_wr);
      mem_wrreq_i = 1'b0;
      tick();
      mem_valid_i = 1'b1;
      mem_wmask_i = 4'hF;
      mem_wdata_i = b[0];
      tick();
      mem_wdata_i = b[1];
      reset       = 1'b1;
      tick();
      check("rst_mid_outputs", 64'({mem_wrack_o, mem_wrerr_o, mem_rdack_o, mem_rderr_o,
                                    mem_ready_o, mem_valid_o, mem_rlast_o, mem_rdata_o}), 64'd0);
      reset       = 1'b0;
      mem_valid_i = 1'b0;
      tick();
      model_write(32'h40, b, '1, 1);
      do_read("rst_rd", 32'h40, model_burst(32'h40), 0, 4'b0010);
      do_write("rst_fix", 32'h40, a, '1, BL, 1'b0, 1'b0);

`ifdef DDR3_SRAM_RESPONDER_ADDR_CHECK_EN
      do_read("oor_rd", 32'h1000, '0, 0, '0);
      do_write("oor_wr", 32'h1040, b, '1, BL, 1'b0, 1'b0);
      do_read("oor_chk", 32'h40, a, 2, '0);
`else
      d = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
      do_write("wrap_wr", 32'h1000, d, '1, BL, 1'b0, 1'b0);
      do_read("wrap_rd", 32'h0, d, 2, '0);
`endif

      // Randomized traffic against the model.
      repeat (16) begin
         addr = 32'($urandom_range(0, 255));
         if ($urandom_range(0, 3) == 0) addr = addr | 32'h1000;
         for (int i = 0; i < BL; i++) begin
            d[i] = $urandom;
            m[i] = 4'($urandom);
         end
         nb = $urandom_range(1, BL);
         do_write("rnd_wr", addr, d, m, nb, (nb == BL) && ($urandom_range(0, 1) == 1), 1'b1);
         do_read("rnd_rd_same", addr, model_burst(addr), 2, '0);
         addr = 32'($urandom_range(0, 255));
         do_read("rnd_rd_other", addr, model_burst(addr), 2, '0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
